dcache_sram_nway: RTL and testbench

- Parametrised N-way set-associative data-cache storage array with true-LRU replacement. Successor to the fixed 2-way, 16-set dcache SRAM; sits between the dcache controller and memory.
- Keeps the same-cycle lookup and posedge write contract.
- Adds a hit-way report and per-set age-based LRU.
- Adds a flush engine that walks every line, hands dirty lines out over a valid/ready write-back channel, then invalidates the whole array.

---
 rtl/dcache_pkg.sv | 24 ++
 rtl/lru_age_set.sv | 66 ++++++
 rtl/dcache_sram_nway.sv | 178 +++++++++++++++++
 tb/tb_dcache_sram_nway.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the N-way dcache storage array: tag-field layout,
// flush FSM states and default geometry.
package dcache_pkg;

  localparam int DEF_TAG_W  = 23;
  localparam int DEF_LINE_W = 256;

  // Tag word layout is {valid, dirty, cpu_tag}.
  function automatic int valid_bit(input int tag_w);
    return tag_w + 1;
  endfunction

  function automatic int dirty_bit(input int tag_w);
    return tag_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WB,
    ST_DONE
  } flush_state_e;

endpackage

// File: rtl/lru_age_set.sv
// Per-set true-LRU ages (0 = most recent) with hit and victim way selection
// for the currently addressed set.
module lru_age_set #(
  parameter int WAYS  = 2,
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WAYS-1:0]  i_valid,
  input  logic [WAYS-1:0]  i_match,
  input  logic             i_update,
  input  logic             i_reset_ages,
  output logic             o_hit,
  output logic [WAY_W-1:0] o_sel_way
);

  localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);

  logic [WAY_W-1:0] r_age [SETS][WAYS];

  logic [WAY_W-1:0] w_hit_way;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_old_way;
  logic [WAY_W-1:0] w_sel_age;
  logic             w_any_inv;

  // Scanning downwards lets the lowest matching way overwrite the others.
  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    w_old_way = '0;
    w_any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (i_match[w]) w_hit_way = WAY_W'(w);
      if (!i_valid[w]) begin
        w_inv_way = WAY_W'(w);
        w_any_inv = 1'b1;
      end
      if (r_age[i_idx][w] == OLDEST) w_old_way = WAY_W'(w);
    end
  end

  assign o_hit     = |i_match;
  assign o_sel_way = o_hit ? w_hit_way : (w_any_inv ? w_inv_way : w_old_way);
  assign w_sel_age = r_age[i_idx][o_sel_way];

  for (genvar gs = 0; gs < SETS; gs++) begin : g_set
    for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
      always_ff @(posedge clk_i) begin
        if (!rst_i || i_reset_ages) begin
          r_age[gs][gw] <= WAY_W'(gw);
        end else if (i_update && (i_idx == IDX_W'(gs))) begin
          if (o_sel_way == WAY_W'(gw)) begin
            r_age[gs][gw] <= '0;
          end else if (r_age[gs][gw] < w_sel_age) begin
            r_age[gs][gw] <= r_age[gs][gw] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache tag/data array with same-cycle lookup, posedge
// writes, true-LRU replacement and a flush engine with a write-back channel.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int IDX_W  = $clog2(SETS),
  parameter int WAY_W  = $clog2(WAYS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TAG_W+1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic [TAG_W+1:0]  tag_o,
  output logic [LINE_W-1:0] data_o,
  output logic              hit_o,
  output logic [WAY_W-1:0]  hit_way_o,
  input  logic              flush_req_i,
  output logic              flush_busy_o,
  output logic              flush_done_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [IDX_W-1:0]  wb_idx_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [LINE_W-1:0] wb_data_o
);

  localparam int               VB       = valid_bit(TAG_W);
  localparam int               DB       = dirty_bit(TAG_W);
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  logic [TAG_W+1:0]  r_tag  [SETS][WAYS];
  logic [LINE_W-1:0] r_data [SETS][WAYS];

  flush_state_e     r_state;
  flush_state_e     w_state_nxt;
  logic [IDX_W-1:0] r_fset;
  logic [WAY_W-1:0] r_fway;

  logic [WAYS-1:0]  w_valid;
  logic [WAYS-1:0]  w_match;
  logic             w_hit_raw;
  logic [WAY_W-1:0] w_sel_way;
  logic             w_cpu_write;
  logic             w_age_update;
  logic             w_clear_line;
  logic             w_advance;
  logic             w_ages_rst;
  logic             w_last_line;
  logic             w_cur_dirty;

  always_comb begin
    w_valid = '0;
    w_match = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_valid[w] = r_tag[addr_i][w][VB];
      w_match[w] = r_tag[addr_i][w][VB] && (r_tag[addr_i][w][TAG_W-1:0] == tag_i[TAG_W-1:0]);
    end
  end

  lru_age_set #(
    .WAYS (WAYS),
    .SETS (SETS),
    .IDX_W(IDX_W),
    .WAY_W(WAY_W)
  ) u_lru (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_idx       (addr_i),
    .i_valid     (w_valid),
    .i_match     (w_match),
    .i_update    (w_age_update),
    .i_reset_ages(w_ages_rst),
    .o_hit       (w_hit_raw),
    .o_sel_way   (w_sel_way)
  );

  assign flush_busy_o = (r_state != ST_IDLE);
  assign flush_done_o = (r_state == ST_DONE);
  assign wb_valid_o   = (r_state == ST_WB);

  assign hit_o     = w_hit_raw && !flush_busy_o;
  assign hit_way_o = w_sel_way;
  assign tag_o     = r_tag[addr_i][w_sel_way];
  assign data_o    = r_data[addr_i][w_sel_way];

  assign w_cpu_write  = enable_i && write_i && !flush_busy_o;
  assign w_age_update = enable_i && !flush_busy_o && (w_hit_raw || write_i);

  assign wb_idx_o  = r_fset;
  assign wb_tag_o  = r_tag[r_fset][r_fway][TAG_W-1:0];
  assign wb_data_o = r_data[r_fset][r_fway];

  assign w_cur_dirty = r_tag[r_fset][r_fway][VB] && r_tag[r_fset][r_fway][DB];
  assign w_last_line = (r_fset == LAST_SET) && (r_fway == LAST_WAY);

  always_comb begin
    w_state_nxt  = r_state;
    w_clear_line = 1'b0;
    w_advance    = 1'b0;
    w_ages_rst   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (flush_req_i) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_cur_dirty) begin
          w_state_nxt = ST_WB;
        end else begin
          w_clear_line = 1'b1;
          w_advance    = 1'b1;
          if (w_last_line) w_state_nxt = ST_DONE;
        end
      end
      ST_WB: begin
        // Payload is read straight from the array, so it stays put until accepted.
        if (wb_ready_i) begin
          w_clear_line = 1'b1;
          w_advance    = 1'b1;
          w_state_nxt  = w_last_line ? ST_DONE : ST_SCAN;
        end
      end
      ST_DONE: begin
        w_ages_rst  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_fset  <= '0;
      r_fway  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE) begin
        r_fset <= '0;
        r_fway <= '0;
      end else if (w_advance) begin
        r_fway <= r_fway + 1'b1;
        if (r_fway == LAST_WAY) r_fset <= r_fset + 1'b1;
      end
    end
  end

  for (genvar gs = 0; gs < SETS; gs++) begin : g_set
    for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
      logic w_flush_sel;
      logic w_cpu_sel;
      assign w_flush_sel = w_clear_line && (r_fset == IDX_W'(gs)) && (r_fway == WAY_W'(gw));
      assign w_cpu_sel   = w_cpu_write && (addr_i == IDX_W'(gs)) && (w_sel_way == WAY_W'(gw));

      // Flush only drops valid/dirty; the line data is deliberately kept.
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          r_tag[gs][gw]  <= '0;
          r_data[gs][gw] <= '0;
        end else if (w_flush_sel) begin
          r_tag[gs][gw][VB] <= 1'b0;
          r_tag[gs][gw][DB] <= 1'b0;
        end else if (w_cpu_sel) begin
          r_tag[gs][gw]  <= tag_i;
          r_data[gs][gw] <= data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed bench for dcache_sram_nway: a 2-way/16-set instance for eviction,
// write-hit and flush scenarios and a 4-way/4-set instance for LRU ordering.
module tb_dcache_sram_nway;

  localparam int TAG_W = 23;
  localparam int TW    = TAG_W + 2;
  localparam int LA    = 256;
  localparam int LB    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       a_addr = '0;
  logic [TW-1:0]    a_tag_i = '0, a_tag_o;
  logic [LA-1:0]    a_data_i = '0, a_data_o;
  logic             a_en = 1'b0, a_wr = 1'b0, a_freq = 1'b0, a_wbr = 1'b0;
  logic             a_hit, a_busy, a_done, a_wbv;
  logic [0:0]       a_hit_way;
  logic [3:0]       a_wb_idx;
  logic [TAG_W-1:0] a_wb_tag;
  logic [LA-1:0]    a_wb_data;

  logic [1:0]       b_addr = '0;
  logic [TW-1:0]    b_tag_i = '0, b_tag_o;
  logic [LB-1:0]    b_data_i = '0, b_data_o;
  logic             b_en = 1'b0, b_wr = 1'b0, b_freq = 1'b0, b_wbr = 1'b0;
  logic             b_hit, b_busy, b_done, b_wbv;
  logic [1:0]       b_hit_way;
  logic [1:0]       b_wb_idx;
  logic [TAG_W-1:0] b_wb_tag;
  logic [LB-1:0]    b_wb_data;

  int n_pass = 0;
  int n_total = 0;

  dcache_sram_nway #(.WAYS(2), .SETS(16), .TAG_W(TAG_W), .LINE_W(LA)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .addr_i(a_addr), .tag_i(a_tag_i), .data_i(a_data_i),
    .enable_i(a_en), .write_i(a_wr), .tag_o(a_tag_o), .data_o(a_data_o), .hit_o(a_hit),
    .hit_way_o(a_hit_way), .flush_req_i(a_freq), .flush_busy_o(a_busy),
    .flush_done_o(a_done), .wb_valid_o(a_wbv), .wb_ready_i(a_wbr), .wb_idx_o(a_wb_idx),
    .wb_tag_o(a_wb_tag), .wb_data_o(a_wb_data)
  );

  dcache_sram_nway #(.WAYS(4), .SETS(4), .TAG_W(TAG_W), .LINE_W(LB)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .addr_i(b_addr), .tag_i(b_tag_i), .data_i(b_data_i),
    .enable_i(b_en), .write_i(b_wr), .tag_o(b_tag_o), .data_o(b_data_o), .hit_o(b_hit),
    .hit_way_o(b_hit_way), .flush_req_i(b_freq), .flush_busy_o(b_busy),
    .flush_done_o(b_done), .wb_valid_o(b_wbv), .wb_ready_i(b_wbr), .wb_idx_o(b_wb_idx),
    .wb_tag_o(b_wb_tag), .wb_data_o(b_wb_data)
  );

  function automatic logic [TW-1:0] mk(input logic v, input logic d, input logic [TAG_W-1:0] t);
    return {v, d, t};
  endfunction

  function automatic logic [LA-1:0] pat(input logic [31:0] x);
    return {8{x}};
  endfunction

  // Drivers: change inputs just after a negedge, then settle 1 time unit.
  task automatic a_drive(input logic en, input logic wr, input logic [3:0] idx,
                         input logic [TW-1:0] tg, input logic [LA-1:0] d);
    @(negedge clk);
    a_en = en; a_wr = wr; a_addr = idx; a_tag_i = tg; a_data_i = d;
    #1;
  endtask

  task automatic b_drive(input logic en, input logic wr, input logic [1:0] idx,
                         input logic [TW-1:0] tg, input logic [LB-1:0] d);
    @(negedge clk);
    b_en = en; b_wr = wr; b_addr = idx; b_tag_i = tg; b_data_i = d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; a_en = 0; a_wr = 0; a_freq = 0; a_wbr = 0; b_en = 0; b_wr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (a_hit !== 1'b0) $display("FAIL rst_hit got=%0b exp=0", a_hit); else n_pass++;
    n_total++; if (a_hit_way !== 1'b0) $display("FAIL rst_way got=%0d exp=0", a_hit_way); else n_pass++;
    n_total++; if (a_tag_o !== '0) $display("FAIL rst_tag got=%h exp=0", a_tag_o); else n_pass++;
    n_total++; if (a_data_o !== '0) $display("FAIL rst_data got=%h exp=0", a_data_o); else n_pass++;
    n_total++; if ({a_busy, a_done, a_wbv} !== 3'b000) $display("FAIL rst_flush got=%b exp=000", {a_busy, a_done, a_wbv}); else n_pass++;
    n_total++; if ({b_hit, b_busy, b_done, b_wbv} !== 4'b0000) $display("FAIL rst_b_ctl got=%b exp=0000", {b_hit, b_busy, b_done, b_wbv}); else n_pass++;
    n_total++; if ({b_wb_idx, b_wb_tag, b_wb_data} !== '0) $display("FAIL rst_b_wb got=%h exp=0", {b_wb_idx, b_wb_tag, b_wb_data}); else n_pass++;
    n_total++; if (dut_a.u_lru.r_age[5][1] !== 1'b1) $display("FAIL rst_age got=%0d exp=1", dut_a.u_lru.r_age[5][1]); else n_pass++;
  endtask

  task automatic test_evict();
    a_drive(1, 1, 4'd3, mk(1, 0, 23'h5), pat(32'h5));
    a_drive(1, 1, 4'd3, mk(1, 0, 23'h6), pat(32'h6));
    a_drive(0, 0, 4'd3, mk(0, 0, 23'h7), '0);
    n_total++; if (a_hit !== 1'b0) $display("FAIL ev_miss7 got=%0b exp=0", a_hit); else n_pass++;
    n_total++; if (a_hit_way !== 1'b0) $display("FAIL ev_victim got=%0d exp=0", a_hit_way); else n_pass++;
    n_total++; if (a_tag_o !== mk(1, 0, 23'h5)) $display("FAIL ev_victim_tag got=%h exp=%h", a_tag_o, mk(1, 0, 23'h5)); else n_pass++;
    a_drive(1, 1, 4'd3, mk(1, 0, 23'h7), pat(32'h7));
    a_drive(0, 0, 4'd3, mk(0, 0, 23'h5), '0);
    n_total++; if (a_hit !== 1'b0) $display("FAIL ev_gone5 got=%0b exp=0", a_hit); else n_pass++;
    a_drive(0, 0, 4'd3, mk(0, 0, 23'h6), '0);
    n_total++; if ({a_hit, a_hit_way} !== 2'b11) $display("FAIL ev_hit6 got=%b exp=11", {a_hit, a_hit_way}); else n_pass++;
    n_total++; if (a_data_o !== pat(32'h6)) $display("FAIL ev_data6 got=%h exp=%h", a_data_o, pat(32'h6)); else n_pass++;
    a_drive(0, 0, 4'd3, mk(0, 0, 23'h7), '0);
    n_total++; if ({a_hit, a_hit_way} !== 2'b10) $display("FAIL ev_hit7 got=%b exp=10", {a_hit, a_hit_way}); else n_pass++;
  endtask

  task automatic test_write_hit();
    a_drive(1, 1, 4'd3, mk(1, 1, 23'h6), pat(32'hA5A5_0006));
    a_drive(0, 0, 4'd3, mk(0, 0, 23'h6), '0);
    n_total++; if ({a_hit, a_hit_way} !== 2'b11) $display("FAIL wh_hit got=%b exp=11", {a_hit, a_hit_way}); else n_pass++;
    n_total++; if (a_tag_o !== mk(1, 1, 23'h6)) $display("FAIL wh_tag got=%h exp=%h", a_tag_o, mk(1, 1, 23'h6)); else n_pass++;
    n_total++; if (a_data_o !== pat(32'hA5A5_0006)) $display("FAIL wh_data got=%h exp=%h", a_data_o, pat(32'hA5A5_0006)); else n_pass++;
    a_drive(0, 0, 4'd3, mk(0, 0, 23'h7), '0);
    n_total++; if (a_tag_o !== mk(1, 0, 23'h7)) $display("FAIL wh_other_tag got=%h exp=%h", a_tag_o, mk(1, 0, 23'h7)); else n_pass++;
    n_total++; if (a_data_o !== pat(32'h7)) $display("FAIL wh_other_data got=%h exp=%h", a_data_o, pat(32'h7)); else n_pass++;
  endtask

  task automatic test_lru4();
    for (int i = 0; i < 4; i++) b_drive(1, 1, 2'd0, mk(1, 0, 23'(10 + i)), 32'(10 + i));
    b_drive(1, 0, 2'd0, mk(0, 0, 23'd10), '0);
    n_total++; if ({b_hit, b_hit_way} !== 3'b100) $display("FAIL lru_readA got=%b exp=100", {b_hit, b_hit_way}); else n_pass++;
    b_drive(0, 0, 2'd0, mk(0, 0, 23'd14), '0);
    n_total++; if ({b_hit, b_hit_way} !== 3'b001) $display("FAIL lru_victimB got=%b exp=001", {b_hit, b_hit_way}); else n_pass++;
    n_total++; if (b_tag_o !== mk(1, 0, 23'd11)) $display("FAIL lru_victimB_tag got=%h exp=%h", b_tag_o, mk(1, 0, 23'd11)); else n_pass++;
    b_drive(1, 1, 2'd0, mk(1, 0, 23'd14), 32'd14);
    b_drive(1, 0, 2'd0, mk(0, 0, 23'd15), '0);
    n_total++; if ({b_hit, b_hit_way} !== 3'b010) $display("FAIL lru_victimC got=%b exp=010", {b_hit, b_hit_way}); else n_pass++;
    b_drive(1, 0, 2'd0, mk(0, 0, 23'd15), '0);
    n_total++; if (b_hit_way !== 2'd2) $display("FAIL lru_readmiss_noupd got=%0d exp=2", b_hit_way); else n_pass++;
    n_total++; if ({dut_b.u_lru.r_age[0][1], dut_b.u_lru.r_age[0][0], dut_b.u_lru.r_age[0][3], dut_b.u_lru.r_age[0][2]} !== 8'b00_01_10_11)
      $display("FAIL lru_ages got=%b exp=00011011", {dut_b.u_lru.r_age[0][1], dut_b.u_lru.r_age[0][0], dut_b.u_lru.r_age[0][3], dut_b.u_lru.r_age[0][2]}); else n_pass++;
    b_drive(1, 1, 2'd0, mk(1, 0, 23'd15), 32'd15);
    b_drive(0, 0, 2'd0, mk(0, 0, 23'd16), '0);
    n_total++; if (b_hit_way !== 2'd3) $display("FAIL lru_victimD got=%0d exp=3", b_hit_way); else n_pass++;
    b_drive(1, 1, 2'd0, mk(1, 0, 23'd16), 32'd16);
    b_drive(0, 0, 2'd0, mk(0, 0, 23'd17), '0);
    n_total++; if (b_hit_way !== 2'd0) $display("FAIL lru_victimA got=%0d exp=0", b_hit_way); else n_pass++;
    b_drive(1, 1, 2'd0, mk(1, 0, 23'd17), 32'd17);
    b_drive(0, 0, 2'd0, mk(0, 0, 23'd18), '0);
    n_total++; if (b_hit_way !== 2'd1) $display("FAIL lru_victimE got=%0d exp=1", b_hit_way); else n_pass++;
  endtask

  task automatic test_flush_wb();
    int k;
    do_reset();
    a_drive(1, 1, 4'd2, mk(1, 0, 23'h11), pat(32'h1111_1111));
    a_drive(1, 1, 4'd2, mk(1, 1, 23'h22), pat(32'hDEAD_BEEF));
    a_drive(1, 1, 4'd5, mk(1, 0, 23'h33), pat(32'h3333_3333));
    a_drive(0, 0, 4'd0, '0, '0);
    n_total++; if (dut_a.u_lru.r_age[2][0] !== 1'b1) $display("FAIL fwb_age_pre got=%0d exp=1", dut_a.u_lru.r_age[2][0]); else n_pass++;
    a_freq = 1'b1; a_wbr = 1'b0; k = 0;
    @(negedge clk); a_freq = 1'b0; k = 1;
    while (!a_wbv && k < 100) begin @(negedge clk); k++; end
    n_total++; if (k !== 7) $display("FAIL fwb_first_valid_cycle got=%0d exp=7", k); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) a_wbr = 1'b1;
      #1;
      n_total++; if ({a_wbv, a_busy, a_wb_idx} !== 6'b11_0010) $display("FAIL fwb_hold%0d got=%b exp=110010", i, {a_wbv, a_busy, a_wb_idx}); else n_pass++;
      n_total++; if ({a_wb_tag, a_wb_data} !== {23'h22, pat(32'hDEAD_BEEF)}) $display("FAIL fwb_payload%0d got=%h/%h", i, a_wb_tag, a_wb_data); else n_pass++;
      @(negedge clk); k++;
    end
    a_wbr = 1'b0; #1;
    n_total++; if (a_wbv !== 1'b0) $display("FAIL fwb_drop got=%0b exp=0", a_wbv); else n_pass++;
    while (!a_done && k < 200) begin @(negedge clk); k++; end
    n_total++; if (k !== 39) $display("FAIL fwb_done_cycle got=%0d exp=39", k); else n_pass++;
    @(negedge clk); #1;
    n_total++; if ({a_busy, a_done} !== 2'b00) $display("FAIL fwb_idle got=%b exp=00", {a_busy, a_done}); else n_pass++;
    n_total++; if ({dut_a.u_lru.r_age[2][0], dut_a.u_lru.r_age[2][1]} !== 2'b01) $display("FAIL fwb_age_reset got=%b exp=01", {dut_a.u_lru.r_age[2][0], dut_a.u_lru.r_age[2][1]}); else n_pass++;
    a_drive(0, 0, 4'd2, mk(0, 0, 23'h11), '0);
    n_total++; if (a_hit !== 1'b0) $display("FAIL fwb_miss11 got=%0b exp=0", a_hit); else n_pass++;
    n_total++; if (a_tag_o !== mk(0, 0, 23'h11)) $display("FAIL fwb_tag_kept got=%h exp=%h", a_tag_o, mk(0, 0, 23'h11)); else n_pass++;
    n_total++; if (a_data_o !== pat(32'h1111_1111)) $display("FAIL fwb_data_kept got=%h exp=%h", a_data_o, pat(32'h1111_1111)); else n_pass++;
    a_drive(0, 0, 4'd2, mk(0, 0, 23'h22), '0);
    n_total++; if (a_hit !== 1'b0) $display("FAIL fwb_miss22 got=%0b exp=0", a_hit); else n_pass++;
    a_drive(0, 0, 4'd5, mk(0, 0, 23'h33), '0);
    n_total++; if (a_hit !== 1'b0) $display("FAIL fwb_miss33 got=%0b exp=0", a_hit); else n_pass++;
  endtask

  task automatic test_flush_clean();
    int k;
    do_reset();
    a_drive(1, 1, 4'd1, mk(1, 0, 23'h44), pat(32'h4444_4444));
    a_drive(1, 1, 4'd4, mk(1, 0, 23'h55), pat(32'h5555_5555));
    a_freq = 1'b1; k = 0;
    n_total++; if (a_busy !== 1'b0) $display("FAIL fcl_busy_c0 got=%0b exp=0", a_busy); else n_pass++;
    @(negedge clk); k = 1;
    a_freq = 1'b0; a_en = 1'b1; a_wr = 1'b0; a_addr = 4'd1; a_tag_i = mk(0, 0, 23'h44); #1;
    n_total++; if ({a_busy, a_hit} !== 2'b10) $display("FAIL fcl_hit_blocked got=%b exp=10", {a_busy, a_hit}); else n_pass++;
    @(negedge clk); k = 2;
    a_en = 1'b1; a_wr = 1'b1; a_addr = 4'd15; a_tag_i = mk(1, 1, 23'h66); a_data_i = pat(32'h6666_6666);
    a_freq = 1'b1;
    @(negedge clk); k = 3;
    a_en = 1'b0; a_wr = 1'b0; a_freq = 1'b0;
    while (!a_done && k < 100) begin @(negedge clk); k++; end
    n_total++; if (k !== 33) $display("FAIL fcl_done_cycle got=%0d exp=33", k); else n_pass++;
    @(negedge clk); #1;
    n_total++; if ({a_busy, a_done} !== 2'b00) $display("FAIL fcl_done_pulse got=%b exp=00", {a_busy, a_done}); else n_pass++;
    a_drive(0, 0, 4'd15, mk(0, 0, 23'h66), '0);
    n_total++; if ({a_hit, a_tag_o} !== '0) $display("FAIL fcl_blocked_tag got=%b/%h exp=0/0", a_hit, a_tag_o); else n_pass++;
    n_total++; if (a_data_o !== '0) $display("FAIL fcl_blocked_data got=%h exp=0", a_data_o); else n_pass++;
    a_drive(0, 0, 4'd4, mk(0, 0, 23'h55), '0);
    n_total++; if ({a_hit, a_tag_o} !== {1'b0, mk(0, 0, 23'h55)}) $display("FAIL fcl_same_cycle_wr got=%b/%h", a_hit, a_tag_o); else n_pass++;
    n_total++; if (a_data_o !== pat(32'h5555_5555)) $display("FAIL fcl_same_cycle_data got=%h", a_data_o); else n_pass++;
    a_drive(0, 0, 4'd1, mk(0, 0, 23'h44), '0);
    n_total++; if (a_hit !== 1'b0) $display("FAIL fcl_miss44 got=%0b exp=0", a_hit); else n_pass++;
  endtask

  task automatic test_reset_mid_wb();
    int k;
    do_reset();
    a_drive(1, 1, 4'd0, mk(1, 1, 23'h77), pat(32'h7777_7777));
    a_drive(1, 1, 4'd2, mk(1, 0, 23'h12), pat(32'h12));
    a_drive(1, 1, 4'd2, mk(1, 0, 23'h13), pat(32'h13));
    a_drive(0, 0, 4'd0, '0, '0);
    a_freq = 1'b1; a_wbr = 1'b0; k = 0;
    @(negedge clk); a_freq = 1'b0; k = 1;
    while (!a_wbv && k < 100) begin @(negedge clk); k++; end
    n_total++; if (k !== 2) $display("FAIL rwb_valid_cycle got=%0d exp=2", k); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    n_total++; if ({a_wbv, a_busy, a_done} !== 3'b000) $display("FAIL rwb_ctl got=%b exp=000", {a_wbv, a_busy, a_done}); else n_pass++;
    n_total++; if ({dut_a.u_lru.r_age[2][0], dut_a.u_lru.r_age[2][1]} !== 2'b01) $display("FAIL rwb_ages got=%b exp=01", {dut_a.u_lru.r_age[2][0], dut_a.u_lru.r_age[2][1]}); else n_pass++;
    a_drive(0, 0, 4'd0, mk(0, 0, 23'h77), '0);
    n_total++; if ({a_hit, a_tag_o} !== '0) $display("FAIL rwb_line0 got=%b/%h exp=0/0", a_hit, a_tag_o); else n_pass++;
    n_total++; if (a_data_o !== '0) $display("FAIL rwb_data0 got=%h exp=0", a_data_o); else n_pass++;
    a_drive(0, 0, 4'd2, mk(0, 0, 23'h13), '0);
    n_total++; if (a_hit !== 1'b0) $display("FAIL rwb_miss13 got=%0b exp=0", a_hit); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_evict();
    test_write_hit();
    test_lru4();
    test_flush_wb();
    test_flush_clean();
    test_reset_mid_wb();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
